// File: rtl/lock_controller.sv
// Two-button electronic lock sequencer.
// Collects CODE_LEN-digit entries and compares each one with a programmable code.
// Runs the timed unlock window, applies lockout after repeated mismatches, and
// discards an entry that stalls mid-way. The code can be reprogrammed only
// while the lock is open.
module lock_controller #(
  parameter int                     CODE_LEN     = 5,
  parameter logic [CODE_LEN-1:0]    DEFAULT_CODE = CODE_LEN'(5'b01011),
  parameter int                     MAX_FAIL     = 3,
  parameter int                     UNLOCK_CYC   = 8,
  parameter int                     LOCKOUT_CYC  = 16,
  parameter int                     TIMEOUT_CYC  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          b0,
  input  logic                          b1,
  input  logic                          lock_now,
  input  logic                          prog_en,
  input  logic [CODE_LEN-1:0]           new_code,
  output logic                          unlock,
  output logic                          lockout,
  output logic                          err,
  output logic                          busy,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int IDL_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int TMR_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // The entry completes on the press that arrives while CNT_LAST digits are already held.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
  localparam logic [IDL_W-1:0]  IDL_LAST  = IDL_W'(TIMEOUT_CYC - 1);
  // Window timers are loaded with (length - 1). The state is left on the edge where the timer reads 0.
  localparam logic [TMR_W-1:0]  UNL_LOAD  = TMR_W'(UNLOCK_CYC - 1);
  localparam logic [TMR_W-1:0]  LO_LOAD   = TMR_W'(LOCKOUT_CYC - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ENTRY    = 2'd1;
  localparam logic [1:0] S_UNLOCKED = 2'd2;
  localparam logic [1:0] S_LOCKOUT  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CODE_LEN-1:0] entry_q, entry_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [IDL_W-1:0]    idle_q,  idle_d;
  logic [TMR_W-1:0]    tmr_q,   tmr_d;
  logic [CODE_LEN-1:0] code_q,  code_d;
  logic [FAIL_W-1:0]   fail_q,  fail_d;
  logic                err_d;

  logic                unlock_q, lockout_q, err_q, busy_q;

  logic                press;
  logic [CODE_LEN-1:0] entry_base;
  logic [CNT_W-1:0]    cnt_base;
  logic [CODE_LEN-1:0] shifted;

  // A press is exactly one button held down. The digit value is b1.
  assign press      = b0 ^ b1;
  // In IDLE the first digit starts from an empty entry, so CODE_LEN==1 also works.
  assign entry_base = (state_q == S_ENTRY) ? entry_q : '0;
  assign cnt_base   = (state_q == S_ENTRY) ? cnt_q   : '0;
  assign shifted    = CODE_LEN'({entry_base, b1});

  // Next-state and datapath decisions for the lock sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    tmr_d   = tmr_q;
    code_d  = code_q;
    fail_d  = fail_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (press) begin
          idle_d = '0;
          if (cnt_base == CNT_LAST) begin
            // The entry is complete: compare it in this cycle and start a fresh entry.
            entry_d = '0;
            cnt_d   = '0;
            if (shifted == code_q) begin
              state_d = S_UNLOCKED;
              tmr_d   = UNL_LOAD;
              fail_d  = '0;
            end else begin
              err_d  = 1'b1;
              fail_d = fail_q + FAIL_W'(1);
              if (fail_q == FAIL_LAST) begin
                state_d = S_LOCKOUT;
                tmr_d   = LO_LOAD;
              end else begin
                state_d = S_IDLE;
              end
            end
          end else begin
            entry_d = shifted;
            cnt_d   = cnt_base + CNT_W'(1);
            state_d = S_ENTRY;
          end
        end else if (state_q == S_ENTRY) begin
          // A stalled entry is dropped silently. It does not count as a failure.
          if (idle_q == IDL_LAST) begin
            state_d = S_IDLE;
            entry_d = '0;
            cnt_d   = '0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IDL_W'(1);
          end
        end
      end

      S_UNLOCKED: begin
        // lock_now overrides prog_en. Reprogramming does not extend the window.
        if (lock_now) begin
          state_d = S_IDLE;
        end else begin
          if (prog_en) code_d = new_code;
          if (tmr_q == '0) state_d = S_IDLE;
          else             tmr_d   = tmr_q - TMR_W'(1);
        end
      end

      S_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Sequence state, entry shift register, counters and code register.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      tmr_q   <= '0;
      // NOTE: the code register is a plain flop bank, so reset restores DEFAULT_CODE.
      code_q  <= DEFAULT_CODE;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      tmr_q   <= tmr_d;
      code_q  <= code_d;
      fail_q  <= fail_d;
    end
  end

  // Output flops are decoded from the next state, so each output is aligned with its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unlock_q  <= 1'b0;
      lockout_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unlock_q  <= (state_d == S_UNLOCKED);
      lockout_q <= (state_d == S_LOCKOUT);
      err_q     <= err_d;
      busy_q    <= (state_d == S_ENTRY);
    end
  end

  assign unlock   = unlock_q;
  assign lockout  = lockout_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller.
// The driver applies inputs once per cycle and pushes the outputs the reference
// model expects after the next edge. The monitor pops and compares each cycle.
module tb_lock_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       b0 = 1'b0, b1 = 1'b0, lock_now = 1'b0, prog_en = 1'b0;
  logic [4:0] new_code = 5'd0;
  logic       unlock, lockout, err, busy;
  logic [1:0] fail_cnt;

  lock_controller dut (
    .clk      (clk),
    .reset    (reset),
    .b0       (b0),
    .b1       (b1),
    .lock_now (lock_now),
    .prog_en  (prog_en),
    .new_code (new_code),
    .unlock   (unlock),
    .lockout  (lockout),
    .err      (err),
    .busy     (busy),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs, packed as {unlock, lockout, err, busy, fail_cnt}.
  logic [5:0] exp_q[$];

  // Reference model: a mode, the digits collected so far, and the remaining window cycles.
  localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_LOCKED = 3;
  int         m_mode;
  bit         m_digits[$];
  int         m_idle_run;
  int         m_left;
  int         m_fail;
  logic [4:0] m_code;

  function automatic logic [5:0] dut_out();
    return {unlock, lockout, err, busy, fail_cnt};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got u/lo/err/busy/fail=%b, expected %b", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    m_mode     = M_IDLE;
    m_digits.delete();
    m_idle_run = 0;
    m_left     = 0;
    m_fail     = 0;
    m_code     = 5'b01011;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, and queue the expected outputs.
  task automatic apply(input logic ib0, input logic ib1, input logic iln,
                       input logic ipe, input logic [4:0] inc);
    bit press;
    bit e_err;
    int value;
    b0 = ib0; b1 = ib1; lock_now = iln; prog_en = ipe; new_code = inc;
    press = ib0 ^ ib1;
    e_err = 1'b0;
    case (m_mode)
      M_IDLE, M_ENTRY: begin
        if (press) begin
          m_digits.push_back(ib1);
          m_idle_run = 0;
          if (m_digits.size() == 5) begin
            value = 0;
            foreach (m_digits[i]) value = value * 2 + int'(m_digits[i]);
            m_digits.delete();
            if (value == int'(m_code)) begin
              m_mode = M_OPEN; m_left = 8; m_fail = 0;
            end else begin
              e_err = 1'b1;
              m_fail++;
              if (m_fail == 3) begin m_mode = M_LOCKED; m_left = 16; end
              else m_mode = M_IDLE;
            end
          end else begin
            m_mode = M_ENTRY;
          end
        end else if (m_mode == M_ENTRY) begin
          m_idle_run++;
          if (m_idle_run == 32) begin
            m_mode = M_IDLE; m_digits.delete(); m_idle_run = 0;
          end
        end
      end
      M_OPEN: begin
        if (iln) m_mode = M_IDLE;
        else begin
          if (ipe) m_code = inc;
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_IDLE; m_fail = 0; end
      end
    endcase
    exp_q.push_back({m_mode == M_OPEN, m_mode == M_LOCKED, e_err, m_mode == M_ENTRY, 2'(m_fail)});
  endtask

  task automatic step(input logic ib0, input logic ib1, input logic iln,
                      input logic ipe, input logic [4:0] inc);
    @(negedge clk);
    apply(ib0, ib1, iln, ipe, inc);
  endtask

  task automatic press_digit(input bit d);
    step(!d, d, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic enter(input logic [4:0] c);
    for (int i = 4; i >= 0; i--) press_digit(c[i]);
  endtask

  // Assert reset between clock edges, check that the outputs clear at once, then release it at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    b0 = 1'b0; b1 = 1'b0; lock_now = 1'b0; prog_en = 1'b0;
    #2 reset = 1'b0;
    #1 check("async_reset", dut_out(), 6'b0);
    model_reset();
    exp_q.push_back(6'b0);
    @(negedge clk);
    reset = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  // Monitor: compare the DUT outputs just after each rising edge with the head of the queue.
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle_outputs", dut_out(), e);
      end
    end
  end

  initial begin
    int r;
    model_reset();
    do_reset();

    // Correct default code unlocks for 8 cycles.
    enter(5'b01011);
    idle(10);

    // Three wrong entries give lockout. Presses during lockout are ignored.
    repeat (3) enter(5'b11111);
    enter(5'b01011);
    idle(14);
    enter(5'b01011);
    idle(10);

    // A stalled partial entry times out.
    press_digit(1'b0); press_digit(1'b1);
    idle(33);
    enter(5'b01011);
    idle(10);

    // Reprogram while unlocked. prog_en while idle is ignored.
    enter(5'b01011);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'b10100);
    idle(9);
    enter(5'b01011);
    enter(5'b10100);
    idle(10);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'b00000);
    enter(5'b10100);
    idle(10);

    // Both buttons held is not a press. lock_now closes the lock early.
    press_digit(1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    idle(25);
    enter(5'b10100);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'b11111);
    idle(3);
    enter(5'b10100);
    idle(10);

    // Reset in the middle of an entry, and reset after a reprogram.
    press_digit(1'b0); press_digit(1'b1); press_digit(1'b0);
    do_reset();
    enter(5'b01011);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'b11100);
    idle(2);
    do_reset();
    enter(5'b01011);
    idle(10);

    // Randomized mix of entries, idle gaps, control inputs and resets.
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: enter(m_code);
        3, 4:    enter(5'($urandom));
        5:       repeat ($urandom_range(1, 4)) press_digit(1'($urandom));
        6:       idle($urandom_range(1, 40));
        7:       step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 5'($urandom));
        8:       repeat ($urandom_range(1, 6)) step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        default: step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
      endcase
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    idle(2);
    repeat (2) @(posedge clk);
    #2;
    check("queue_drain", 6'(exp_q.size()), 6'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
